pci_initiator: RTL

PCI bus initiator (master) that sits directly upstream of the team's PCI target device. It turns a single-request local command into a PCI address phase followed by a burst of 1..MAX_BURST data phases. It drives FRAME/IRDY/C_BE/AD/rw into the target and consumes DEVSEL/TRDY, hands read data back to the local side, and reports completion, target disconnect and master abort.

---
 rtl/pci_pkg.sv | 22 ++
 rtl/pci_devsel_timer.sv | 35 +++
 rtl/pci_initiator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI initiator: bus command codes, the idle AD
// value and the initiator state encoding.
package pci_pkg;

  localparam logic [3:0]  CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WRITE = 4'b0111;
  localparam logic [3:0]  BE_ALL        = 4'hF;
  localparam logic [31:0] AD_IDLE       = 32'bz;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    TURN,
    ABORT
  } pci_state_e;

  function automatic logic [3:0] cmd_code(input logic is_write);
    return is_write ? CMD_MEM_WRITE : CMD_MEM_READ;
  endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// Counts consecutive DATA cycles without DEVSEL; o_timeout flags the cycle that
// completes the TIMEOUT-th such cycle so the initiator can master-abort.
module pci_devsel_timer
  import pci_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in_data,
  input  logic i_devsel_n,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;
  logic          w_counting;

  assign w_counting = i_in_data && i_devsel_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (!w_counting) begin
      r_count <= '0;
    end else if (r_count != CW'(TIMEOUT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The current cycle is the last one allowed, so the abort is taken at this edge.
  assign o_timeout = w_counting && (r_count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/pci_initiator.sv
// PCI memory read/write initiator: one address phase and 1..MAX_BURST data phases.
// Optional IRDY wait-state injection port enabled by PCI_INIT_WAIT_INJECT_EN.
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 3,
  parameter int DEVSEL_TIMEOUT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_cmd_write,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_len,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_be,
  output logic        o_wr_pop,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort,
  output logic [1:0]  o_xfer_count,
  output logic        o_frame_n,
  output logic        o_irdy_n,
  output logic [3:0]  o_c_be,
  inout  wire  [31:0] io_ad,
  output logic        o_rw,
  input  logic        i_devsel_n,
  input  logic        i_trdy_n
`ifdef PCI_INIT_WAIT_INJECT_EN
  ,
  input  logic        i_irdy_hold
`endif
);

  pci_state_e  r_state;
  pci_state_e  w_next;

  logic        r_cmd_write;
  logic [31:0] r_addr;
  logic [1:0]  r_remaining;
  logic [1:0]  r_xfer_count;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_devsel_seen;

  logic        w_hold;
  logic [1:0]  w_len;
  logic        w_in_data;
  logic        w_irdy_n;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_disconnect;
  logic        w_timeout;
  logic        w_accept;

  logic        w_frame_n;
  logic [3:0]  w_c_be;
  logic [31:0] w_ad_out;
  logic        w_ad_oe;
  logic        w_rw;
  logic        w_done;
  logic        w_abort;
  logic        w_pop;

`ifdef PCI_INIT_WAIT_INJECT_EN
  assign w_hold = i_irdy_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_len        = (int'(i_len) > MAX_BURST) ? 2'(MAX_BURST) : i_len;
  assign w_in_data    = (r_state == DATA);
  assign w_irdy_n     = !(w_in_data && !w_hold);
  assign w_beat       = w_in_data && !w_irdy_n && !i_devsel_n && !i_trdy_n;
  assign w_last_beat  = w_beat && (r_remaining == 2'd1);
  // DEVSEL going away after a claim is a target disconnect, not a master abort.
  assign w_disconnect = w_in_data && i_devsel_n && r_devsel_seen;
  assign w_accept     = (r_state == IDLE) && i_req && (i_len != 2'd0);

  pci_devsel_timer #(
    .TIMEOUT(DEVSEL_TIMEOUT)
  ) u_devsel_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_in_data (w_in_data),
    .i_devsel_n(i_devsel_n),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_frame_n = 1'b1;
    w_c_be    = BE_ALL;
    w_ad_out  = '0;
    w_ad_oe   = 1'b0;
    w_rw      = 1'b1;
    w_done    = 1'b0;
    w_abort   = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req && !i_reset) begin
          if (i_len == 2'd0) begin
            w_abort = 1'b1;
            w_done  = 1'b1;
          end else begin
            w_next = ADDR;
          end
        end
      end
      ADDR: begin
        w_frame_n = 1'b0;
        w_ad_oe   = 1'b1;
        w_ad_out  = r_addr;
        w_c_be    = cmd_code(r_cmd_write);
        w_next    = DATA;
      end
      DATA: begin
        w_frame_n = (r_remaining == 2'd1);
        if (r_cmd_write) begin
          w_ad_oe  = 1'b1;
          w_ad_out = i_wr_data;
          w_c_be   = i_wr_be;
          w_pop    = w_beat;
        end else begin
          w_rw = 1'b0;
        end
        if (w_last_beat || w_disconnect) begin
          w_next = TURN;
        end else if (w_timeout) begin
          w_next = ABORT;
        end
      end
      TURN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      ABORT: begin
        w_done  = 1'b1;
        w_abort = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmd_write   <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_xfer_count  <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_devsel_seen <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_cmd_write   <= i_cmd_write;
        r_addr        <= i_addr;
        r_remaining   <= w_len;
        r_xfer_count  <= '0;
        r_devsel_seen <= 1'b0;
      end
      if (w_in_data) begin
        if (!i_devsel_n) begin
          r_devsel_seen <= 1'b1;
        end
        if (w_beat) begin
          r_remaining  <= r_remaining - 2'd1;
          r_xfer_count <= r_xfer_count + 2'd1;
          if (!r_cmd_write) begin
            r_rd_data  <= io_ad;
            r_rd_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign io_ad        = w_ad_oe ? w_ad_out : AD_IDLE;
  assign o_frame_n    = w_frame_n;
  assign o_irdy_n     = w_irdy_n;
  assign o_c_be       = w_c_be;
  assign o_rw         = w_rw;
  assign o_wr_pop     = w_pop;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = w_done;
  assign o_abort      = w_abort;
  assign o_xfer_count = r_xfer_count;

endmodule
